// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage 16-bit pipeline.
// Holds issue-action encodings, register index width and bubble value.
package pipe_pkg;

  localparam int REGW = 3;

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_LU     = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } act_e;

  localparam logic BUBBLE = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Issue/hazard control: load-use stalls, redirect flushes,
// memory-data bypass selects and debug stall/flush counters.
module ex_hazard_ctrl #(
  parameter int REGW = pipe_pkg::REGW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_is_load,
  input  logic [REGW-1:0] id_rd,
  input  logic            ex_pcsrc,
  input  logic            mem_busy,
  input  logic            cnt_clr,
  output logic            stall_if,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            load_warning_a,
  output logic            load_warning_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  import pipe_pkg::*;

  logic            ex_ld_v;
  logic [REGW-1:0] ex_ld_rd;
  logic            mem_ld_v;
  logic [REGW-1:0] mem_ld_rd;
  act_e            act;
  act_e            act_nxt;

  logic hit_rs;
  logic hit_rt;
  logic hazard;
  logic freeze;
  logic flush;
  logic lu;
  logic issue;
  logic wa_nxt;
  logic wb_nxt;

  assign hit_rs = id_uses_rs & (id_rs == ex_ld_rd);
  assign hit_rt = id_uses_rt & (id_rt == ex_ld_rd);

  // A stalled consumer always sees a bubble in EX next cycle.
  assign hazard = id_valid & ex_ld_v & (hit_rs | hit_rt)
                & (act != ACT_LU);

  assign freeze = mem_busy;
  assign flush  = ~freeze & ex_pcsrc;
  assign lu     = ~freeze & ~ex_pcsrc & hazard;
  assign issue  = ~freeze & ~ex_pcsrc & ~hazard;

  assign stall_if    = freeze | lu;
  assign stall_id    = freeze | lu;
  assign bubble_ex   = lu;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;

  assign wa_nxt = id_uses_rs & mem_ld_v & (id_rs == mem_ld_rd);
  assign wb_nxt = id_uses_rt & mem_ld_v & (id_rt == mem_ld_rd);

  always_comb begin
    act_nxt = ACT_RUN;
    unique case (1'b1)
      freeze:  act_nxt = ACT_FREEZE;
      flush:   act_nxt = ACT_FLUSH;
      lu:      act_nxt = ACT_LU;
      default: act_nxt = ACT_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ld_v        <= 1'b0;
      ex_ld_rd       <= '0;
      mem_ld_v       <= 1'b0;
      mem_ld_rd      <= '0;
      load_warning_a <= 1'b0;
      load_warning_b <= 1'b0;
      act            <= ACT_RUN;
    end else begin
      act <= act_nxt;
      if (!freeze) begin
        mem_ld_v  <= ex_ld_v;
        mem_ld_rd <= ex_ld_rd;
        if (issue) begin
          ex_ld_v        <= id_valid & id_is_load;
          ex_ld_rd       <= id_rd;
          load_warning_a <= wa_nxt;
          load_warning_b <= wb_nxt;
        end else begin
          ex_ld_v        <= BUBBLE;
          ex_ld_rd       <= '0;
          load_warning_a <= 1'b0;
          load_warning_b <= 1'b0;
        end
      end
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (lu),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush),
    .cnt (flush_cnt)
  );

endmodule
